// File: rtl/floating_point_pkg.sv
// Shared encodings for the single-precision floating-point sequencer:
// FSM states, command codes and datapath opcode constants.
package floating_point_pkg;

    localparam int MUL_CYCLES_DEF = 24;
    localparam int ALIGN_MAX_DEF  = 25;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_e;

    localparam logic [3:0] IOD_INC   = 4'b0000;
    localparam logic [3:0] IOD_DEC   = 4'b0011;
    localparam logic [3:0] SALU_PASS = 4'b0000;
    localparam logic [3:0] SALU_SUB  = 4'b0011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXP_CMP,
        S_ALIGN,
        S_ADD,
        S_MUL_INIT,
        S_MUL_STEP,
        S_NORMALIZE,
        S_ROUND,
        S_RENORM,
        S_DONE
    } state_e;

endpackage

// File: rtl/floating_point_control_if.sv
// Command, status and control bundle between the sequencer and the
// floating-point datapath; master is the sequencer side.
interface floating_point_control_if;

    logic        start;
    logic [1:0]  op;
    logic        sign1;
    logic        sign2;
    logic        expFirstSmaller;
    logic [7:0]  expDiff;
    logic        sumCarry;
    logic [4:0]  leadingZeros;
    logic        mantissaZero;
    logic        roundCarry;

    logic        controlToMux01;
    logic        controlToMux02;
    logic        controlToMux03;
    logic        controlToMux04;
    logic        controlToMux05;
    logic [7:0]  controlShiftRight;
    logic [3:0]  controlToIncreaseOrDecrease;
    logic        IncreaseOrDecreaseEnable;
    logic [7:0]  howManyToIncreaseOrDecrease;
    logic        rightOrLeft;
    logic [22:0] howMany;
    logic        isSum;
    logic        sum_sub;
    logic        dpReset;
    logic        muxDataRegValor2;
    logic        endMultiplication;
    logic [3:0]  smallALUOperation;
    logic        muxAControlSmall;
    logic        muxBControlSmall;
    logic        loadRegSmall;
    logic        busy;
    logic        done;

    modport master (
        input  start, op, sign1, sign2, expFirstSmaller, expDiff,
        input  sumCarry, leadingZeros, mantissaZero, roundCarry,
        output controlToMux01, controlToMux02, controlToMux03,
        output controlToMux04, controlToMux05, controlShiftRight,
        output controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable,
        output howManyToIncreaseOrDecrease, rightOrLeft, howMany,
        output isSum, sum_sub, dpReset, muxDataRegValor2,
        output endMultiplication, smallALUOperation,
        output muxAControlSmall, muxBControlSmall, loadRegSmall,
        output busy, done
    );

    modport slave (
        output start, op, sign1, sign2, expFirstSmaller, expDiff,
        output sumCarry, leadingZeros, mantissaZero, roundCarry,
        input  controlToMux01, controlToMux02, controlToMux03,
        input  controlToMux04, controlToMux05, controlShiftRight,
        input  controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable,
        input  howManyToIncreaseOrDecrease, rightOrLeft, howMany,
        input  isSum, sum_sub, dpReset, muxDataRegValor2,
        input  endMultiplication, smallALUOperation,
        input  muxAControlSmall, muxBControlSmall, loadRegSmall,
        input  busy, done
    );

endinterface

// File: rtl/floating_point_step_counter.sv
// Loadable down-counter for the multiply shift-add loop; term_o marks
// the final iteration (count at zero).
module floating_point_step_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign term_o = (cnt_q == '0);

endmodule

// File: rtl/floating_point_control.sv
// Sequencing FSM for the single-precision add/sub/mul datapath: decodes
// every datapath control line from the state and the accepted command.
module floating_point_control
    import floating_point_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int ALIGN_MAX  = ALIGN_MAX_DEF
) (
    input logic                      clk,
    input logic                      reset,
    floating_point_control_if.master bus
);

    localparam logic [4:0] STEP_LAST = 5'(MUL_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] op_q;
    logic       sign_x_q;
    logic       efs_q;
    logic       eff_sub;
    logic       step_last;
    logic [7:0] align_amt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            sign_x_q <= 1'b0;
            efs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.start) begin
                op_q     <= bus.op;
                sign_x_q <= bus.sign1 ^ bus.sign2;
                efs_q    <= bus.expFirstSmaller;
            end
        end
    end

    floating_point_step_counter #(.W(5)) u_steps (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (state_q == S_MUL_INIT),
        .load_val_i (STEP_LAST),
        .en_i       (state_q == S_MUL_STEP),
        .term_o     (step_last)
    );

    assign eff_sub   = sign_x_q ^ (op_q == OP_SUB);
    assign align_amt = (int'(bus.expDiff) > ALIGN_MAX) ?
                       8'(ALIGN_MAX) : bus.expDiff;

    always_comb begin
        state_d                         = state_q;
        bus.controlToMux01              = 1'b0;
        bus.controlToMux02              = 1'b0;
        bus.controlToMux03              = 1'b0;
        bus.controlToMux04              = 1'b0;
        bus.controlToMux05              = 1'b0;
        bus.controlShiftRight           = 8'd0;
        bus.controlToIncreaseOrDecrease = IOD_INC;
        bus.IncreaseOrDecreaseEnable    = 1'b0;
        bus.howManyToIncreaseOrDecrease = 8'd0;
        bus.rightOrLeft                 = 1'b0;
        bus.howMany                     = 23'd0;
        bus.isSum                       = 1'b1;
        bus.sum_sub                     = 1'b0;
        bus.dpReset                     = 1'b0;
        bus.muxDataRegValor2            = 1'b0;
        bus.endMultiplication           = 1'b0;
        bus.smallALUOperation           = SALU_PASS;
        bus.muxAControlSmall            = 1'b0;
        bus.muxBControlSmall            = 1'b0;
        bus.loadRegSmall                = 1'b0;
        bus.done                        = 1'b0;
        bus.busy                        = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start)
                    state_d = (bus.op == OP_MUL) ? S_MUL_INIT : S_EXP_CMP;
            end
            S_EXP_CMP: begin
                bus.smallALUOperation = SALU_SUB;
                bus.loadRegSmall      = 1'b1;
                state_d               = S_ALIGN;
            end
            S_ALIGN: begin
                bus.controlToMux01    = efs_q;
                bus.controlToMux03    = !efs_q;
                bus.controlToMux04    = efs_q;
                bus.controlShiftRight = align_amt;
                state_d               = S_ADD;
            end
            S_ADD: begin
                bus.controlToMux01 = efs_q;
                bus.controlToMux03 = !efs_q;
                bus.controlToMux04 = efs_q;
                bus.sum_sub        = eff_sub;
                state_d            = S_NORMALIZE;
            end
            S_MUL_INIT: begin
                bus.dpReset          = 1'b1;
                bus.muxAControlSmall = 1'b1;
                bus.muxBControlSmall = 1'b1;
                bus.loadRegSmall     = 1'b1;
                state_d              = S_MUL_STEP;
            end
            S_MUL_STEP: begin
                bus.isSum             = 1'b0;
                bus.muxDataRegValor2  = 1'b1;
                bus.endMultiplication = step_last;
                if (step_last)
                    state_d = S_NORMALIZE;
            end
            S_NORMALIZE: begin
                // Carry out wins over leading zeros; a zero result needs no fix-up
                if (bus.mantissaZero) begin
                end else if (bus.sumCarry) begin
                    bus.rightOrLeft                 = 1'b1;
                    bus.howMany                     = 23'd1;
                    bus.IncreaseOrDecreaseEnable    = 1'b1;
                    bus.howManyToIncreaseOrDecrease = 8'd1;
                end else if (bus.leadingZeros != 5'd0) begin
                    bus.howMany                     = {18'd0, bus.leadingZeros};
                    bus.IncreaseOrDecreaseEnable    = 1'b1;
                    bus.controlToIncreaseOrDecrease = IOD_DEC;
                    bus.howManyToIncreaseOrDecrease = {3'd0, bus.leadingZeros};
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                state_d = bus.roundCarry ? S_RENORM : S_DONE;
            end
            S_RENORM: begin
                bus.controlToMux02              = 1'b1;
                bus.controlToMux05              = 1'b1;
                bus.rightOrLeft                 = 1'b1;
                bus.howMany                     = 23'd1;
                bus.IncreaseOrDecreaseEnable    = 1'b1;
                bus.howManyToIncreaseOrDecrease = 8'd1;
                state_d                         = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_floating_point_control.sv
// Bench for floating_point_control: directed vector table, reset corner
// case and randomized commands against a cycle-index reference model.
module tb_floating_point_control;

    localparam int MC = 24;
    localparam int AM = 25;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    floating_point_control_if bus();

    floating_point_control #(
        .MUL_CYCLES (MC),
        .ALIGN_MAX  (AM)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        m1, m2, m3, m4, m5;
        logic [7:0]  shr;
        logic [3:0]  iod;
        logic        iode;
        logic [7:0]  hmi;
        logic        rol;
        logic [22:0] hm;
        logic        is_sum, ss, dpr, mdr, endm;
        logic [3:0]  sop;
        logic        ma, mb, ld, busy, done;
    } ctl_t;

    typedef struct packed {
        logic [1:0] op;
        logic       s1, s2, efs;
        logic [7:0] ed;
        logic       sc;
        logic [4:0] lz;
        logic       mz, rc;
    } cmd_t;

    typedef struct packed {
        cmd_t       c;
        int         lat;
        logic [7:0] shr;
        logic       ss;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;

    function automatic ctl_t dflt();
        ctl_t e;
        e = '0;
        e.is_sum = 1'b1;
        return e;
    endfunction

    function automatic ctl_t sample();
        ctl_t a;
        a.m1 = bus.controlToMux01;  a.m2 = bus.controlToMux02;
        a.m3 = bus.controlToMux03;  a.m4 = bus.controlToMux04;
        a.m5 = bus.controlToMux05;  a.shr = bus.controlShiftRight;
        a.iod = bus.controlToIncreaseOrDecrease;
        a.iode = bus.IncreaseOrDecreaseEnable;
        a.hmi = bus.howManyToIncreaseOrDecrease;
        a.rol = bus.rightOrLeft;    a.hm = bus.howMany;
        a.is_sum = bus.isSum;       a.ss = bus.sum_sub;
        a.dpr = bus.dpReset;        a.mdr = bus.muxDataRegValor2;
        a.endm = bus.endMultiplication;
        a.sop = bus.smallALUOperation;
        a.ma = bus.muxAControlSmall; a.mb = bus.muxBControlSmall;
        a.ld = bus.loadRegSmall;    a.busy = bus.busy;
        a.done = bus.done;
        return a;
    endfunction

    function automatic int lat(cmd_t c);
        return ((c.op == 2'b10) ? MC + 4 : 6) + (c.rc ? 1 : 0);
    endfunction

    // Expected controls k cycles after the accepting edge, from the cycle map
    function automatic ctl_t model(cmd_t c, int k);
        ctl_t e;
        bit mul, es;
        int L, nk;
        e   = dflt();
        mul = (c.op == 2'b10);
        es  = c.s1 ^ c.s2 ^ (c.op == 2'b01);
        L   = lat(c);
        nk  = mul ? MC + 2 : 4;
        if (k < 1 || k > L) return e;
        e.busy = 1'b1;
        if (k == L) begin
            e.done = 1'b1;
        end else if (k == nk) begin
            if (c.mz) begin
            end else if (c.sc) begin
                e.rol = 1'b1; e.hm = 23'd1; e.iode = 1'b1; e.hmi = 8'd1;
            end else if (c.lz != 0) begin
                e.hm = 23'(c.lz); e.iode = 1'b1;
                e.iod = 4'b0011; e.hmi = 8'(c.lz);
            end
        end else if (k == nk + 2) begin
            e.m2 = 1'b1; e.m5 = 1'b1; e.rol = 1'b1; e.hm = 23'd1;
            e.iode = 1'b1; e.hmi = 8'd1;
        end else if (k == nk + 1) begin
        end else if (!mul) begin
            if (k == 1) begin
                e.sop = 4'b0011; e.ld = 1'b1;
            end else begin
                e.m1 = c.efs; e.m3 = !c.efs; e.m4 = c.efs;
                if (k == 2) e.shr = (c.ed > AM) ? 8'(AM) : c.ed;
                else        e.ss = es;
            end
        end else if (k == 1) begin
            e.dpr = 1'b1; e.ma = 1'b1; e.mb = 1'b1; e.ld = 1'b1;
        end else begin
            e.is_sum = 1'b0; e.mdr = 1'b1; e.endm = (k == MC + 1);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input ctl_t a, input ctl_t e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    task automatic drive(input cmd_t c);
        bus.op = c.op; bus.sign1 = c.s1; bus.sign2 = c.s2;
        bus.expFirstSmaller = c.efs; bus.expDiff = c.ed;
        bus.sumCarry = c.sc; bus.leadingZeros = c.lz;
        bus.mantissaZero = c.mz; bus.roundCarry = c.rc;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle
    task automatic run_op(input cmd_t c, input bit noisy, input string nm,
                          output int done_at, output logic [7:0] shr2,
                          output logic ss3);
        int L;
        ctl_t a;
        L = lat(c);
        done_at = -1; shr2 = '0; ss3 = 1'b0;
        drive(c);
        bus.start = 1'b1;
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            a = sample();
            chk($sformatf("%s_cyc%0d", nm, k), a, model(c, k));
            if (a.done && done_at < 0) done_at = k;
            if (k == 2) shr2 = a.shr;
            if (k == 3) ss3 = a.ss;
            if (noisy && k <= L) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op = 2'($urandom_range(0, 3));
                bus.sign1 = 1'($urandom_range(0, 1));
                bus.sign2 = 1'($urandom_range(0, 1));
                bus.expFirstSmaller = 1'($urandom_range(0, 1));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        int d;
        logic [7:0] s2;
        logic s3;
        cmd_t c;
        bus.start = 1'b0;
        drive('0);

        vecs[0] = '{'{2'b00, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 5'd0, 1'b0, 1'b0}, 6, 8'd2, 1'b0};
        vecs[1] = '{'{2'b00, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 5'd0, 1'b0, 1'b0}, 6, 8'd2, 1'b0};
        vecs[2] = '{'{2'b00, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 5'd0, 1'b0, 1'b0}, 6, 8'd2, 1'b1};
        vecs[3] = '{'{2'b01, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 5'd0, 1'b0, 1'b0}, 6, 8'd2, 1'b1};
        vecs[4] = '{'{2'b10, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 5'd1, 1'b0, 1'b0}, 28, 8'd0, 1'b0};
        vecs[5] = '{'{2'b00, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 5'd0, 1'b0, 1'b1}, 7, 8'd1, 1'b0};
        vecs[6] = '{'{2'b11, 1'b1, 1'b0, 1'b1, 8'd25, 1'b0, 5'd3, 1'b0, 1'b0}, 6, 8'd25, 1'b1};
        vecs[7] = '{'{2'b00, 1'b1, 1'b1, 1'b0, 8'd200, 1'b0, 5'd7, 1'b0, 1'b0}, 6, 8'd25, 1'b0};
        vecs[8] = '{'{2'b01, 1'b1, 1'b0, 1'b1, 8'd26, 1'b1, 5'd5, 1'b1, 1'b0}, 6, 8'd25, 1'b0};
        vecs[9] = '{'{2'b10, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 5'd2, 1'b0, 1'b1}, 29, 8'd0, 1'b0};

        #1 rst_n = 1'b0;
        #1 chk("reset_async", sample(), dflt());
        repeat (2) @(negedge clk);
        chk("reset_held", sample(), dflt());
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle", sample(), dflt());

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].c, 1'b0, $sformatf("vec%0d", i), d, s2, s3);
            chki($sformatf("vec%0d_latency", i), d, vecs[i].lat);
            chki($sformatf("vec%0d_shr", i), int'(s2), int'(vecs[i].shr));
            chki($sformatf("vec%0d_sumsub", i), int'(s3), int'(vecs[i].ss));
        end

        // Reset during the tenth multiply step, start pulsed while in reset
        c = vecs[4].c;
        drive(c);
        bus.start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("rstmul_cyc%0d", k), sample(), model(c, k));
            bus.start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 chk("rstmul_async", sample(), dflt());
        bus.start = 1'b1;
        @(negedge clk);
        chk("rstmul_held", sample(), dflt());
        bus.start = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk($sformatf("rstmul_quiet%0d", k), sample(), dflt());
        end
        run_op(c, 1'b1, "postrst_mul", d, s2, s3);
        chki("postrst_mul_latency", d, MC + 4);

        for (int i = 0; i < 40; i++) begin
            c.op  = 2'($urandom_range(0, 3));
            c.s1  = 1'($urandom_range(0, 1));
            c.s2  = 1'($urandom_range(0, 1));
            c.efs = 1'($urandom_range(0, 1));
            c.ed  = ($urandom_range(0, 3) == 0) ?
                    8'($urandom_range(0, 255)) : 8'($urandom_range(0, 30));
            c.sc  = 1'($urandom_range(0, 1));
            c.lz  = 5'($urandom_range(0, 31));
            c.mz  = ($urandom_range(0, 3) == 0);
            c.rc  = 1'($urandom_range(0, 1));
            run_op(c, 1'b1, $sformatf("rnd%0d", i), d, s2, s3);
            chki($sformatf("rnd%0d_latency", i), d, lat(c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/floating_point_control.md
Name: floating_point_control

Overview:
- Sequencing FSM for the single-precision floating_point datapath.
- Accepts an add/sub/mul command and drives every datapath control line cycle by cycle (muxes, shifters, small ALU, big ALU, increment/decrease unit), replacing hand-driven control vectors.
- Consumes datapath status flags (exponent compare, carry, leading zeros, round overflow) to choose alignment, normalization and renormalization steps.
- Signals completion with a one-cycle done pulse.

Parameters:
- MUL_CYCLES, 24, shift-add iterations of big ALU per multiply.
- ALIGN_MAX, 25, clamp for alignment shift amount.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- op  in  2  00 add, 01 sub, 10 mul; 11 is treated as add.
- sign1, sign2  in  1 each  operand sign bits.
- expFirstSmaller  in  1  exponent of operand 1 is less than exponent of operand 2.
- expDiff  in  8  absolute exponent difference, from small ALU.
- sumCarry  in  1  mantissa carry out of big ALU.
- leadingZeros  in  5  leading-zero count of big ALU result.
- mantissaZero  in  1  big ALU result is zero.
- roundCarry  in  1  rounder overflow.
- controlToMux01..controlToMux05  out  1 each  datapath mux selects.
- controlShiftRight  out  8  alignment shift amount.
- controlToIncreaseOrDecrease  out  4  0000 increment, 0011 decrement.
- IncreaseOrDecreaseEnable  out  1  exponent adjust enable.
- howManyToIncreaseOrDecrease  out  8  exponent adjust amount.
- rightOrLeft  out  1  normalize shifter direction; 1 right, 0 left.
- howMany  out  23  normalize shift amount.
- isSum, sum_sub, dpReset, muxDataRegValor2, endMultiplication  out  1 each  big ALU controls.
- smallALUOperation  out  4  small ALU opcode.
- muxAControlSmall, muxBControlSmall, loadRegSmall  out  1 each  small ALU controls.
- busy, done  out  1 each  status.

Behaviour:
- Outputs are decoded from the current state plus operand attributes latched on the edge that accepts start.
- Latched attributes: op, effSub = sign1^sign2^(op==01), expFirstSmaller.
- IDLE defaults: all mux selects 0, all shift and adjust amounts 0, IncreaseOrDecreaseEnable 0, isSum 1, sum_sub 0, dpReset 0, muxDataRegValor2 0, endMultiplication 0, smallALUOperation 0000, small muxes 0, loadRegSmall 0, busy 0, done 0. These are also the reset values.
- Add/sub path: IDLE -> EXP_CMP -> ALIGN -> ADD -> NORMALIZE -> ROUND -> [RENORM] -> DONE -> IDLE.
- Mul path: IDLE -> MUL_INIT -> MUL_STEP (repeated MUL_CYCLES times) -> NORMALIZE -> ROUND -> [RENORM] -> DONE -> IDLE.
- EXP_CMP: smallALUOperation 0011, loadRegSmall 1.
- ALIGN:
  - If expFirstSmaller: mux01=1, mux03=0, mux04=1.
  - Else: mux01=0, mux03=1, mux04=0.
  - controlShiftRight = min(expDiff, ALIGN_MAX).
- ADD: isSum 1, sum_sub = effSub; mux selects held from ALIGN.
- MUL_INIT: dpReset 1, muxAControlSmall=muxBControlSmall=1, smallALUOperation 0000, loadRegSmall 1.
- MUL_STEP:
  - isSum 0, muxDataRegValor2 1.
  - A 5-bit counter runs 0..MUL_CYCLES-1; endMultiplication is high in the last step only.
- NORMALIZE:
  - If mantissaZero: no shift, no exponent adjust.
  - Else if sumCarry: rightOrLeft 1, howMany 1, increment exponent by 1.
  - Else if leadingZeros > 0: rightOrLeft 0, howMany = leadingZeros, decrement exponent by leadingZeros.
  - IncreaseOrDecreaseEnable is 1 whenever an adjust occurs.
- ROUND: go to RENORM if roundCarry, else to DONE.
- RENORM: mux02=1, mux05=1, rightOrLeft 1, howMany 1, increment exponent by 1.
- DONE: done=1 for exactly one cycle; busy=1 in every state except IDLE.
- Latency, counted from the edge that samples start to the cycle where done is high:
  - add/sub: 6 cycles, or 7 with RENORM.
  - mul: MUL_CYCLES+4 cycles, or MUL_CYCLES+5 with RENORM.
- start while busy: ignored, with no effect on latched operands.
- start high in the DONE cycle: ignored. A new command needs start high in IDLE.
- Reset low at any time: immediate return to IDLE with all outputs at default; the counter clears. An in-flight operation is discarded and done is not pulsed.
- Status inputs are sampled only in the state that uses them.

Decomposition:
- floating_point_pkg holds:
  - state encoding;
  - op codes ADD/SUB/MUL;
  - increment/decrement codes 0000/0011;
  - small ALU opcodes 0000 and 0011;
  - MUL_CYCLES default.
- Sub-module floating_point_step_counter: loadable down-counter with terminal flag, used for MUL_STEP.

Test Plan:
- op=add, 0.75+2.25 (expFirstSmaller=1, expDiff=2, sumCarry=0, leadingZeros=0) -> mux01=1, mux04=1, controlShiftRight=2 in ALIGN; done 6 cycles after start; datapath result 0x40400000.
- op=add, 31.5+4.25 (expFirstSmaller=0, expDiff=2, sumCarry=1) -> mux03=1; NORMALIZE drives rightOrLeft=1, increment by 1; result 0x420F0000.
- op=add, 31.5 + (-4.25) -> sum_sub=1 in ADD; result 0x41DA0000. op=sub, 31.5-4.25 -> identical control trace.
- op=mul, 3.34543*0.38 -> dpReset pulses once; endMultiplication high only in step 24; done at cycle 28; result 0x3FA2B8C2.
- op=add, 2.49999976+1.50000012 with roundCarry=1 -> RENORM asserts mux02=mux05=1, increment by 1; done at cycle 7; result 0x40800000.
- reset low during MUL_STEP 10, then start pulsed while busy -> outputs go to defaults immediately and no done pulse occurs; a start pulsed while busy is ignored with no change to the control trace.
